// File: rtl/stream_fifo_if.sv
// Valid/ready stream bundle for stream_fifo: write side, read side and occupancy status.
// The slave modport is the FIFO's view; the master modport is the producer/consumer view.
interface stream_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [ADDR_WIDTH:0]   count;
  logic                  almost_full;
  logic                  almost_empty;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, count, almost_full, almost_empty
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, count, almost_full, almost_empty
  );
endinterface

// File: rtl/stream_fifo.sv
// First-word-fall-through synchronous FIFO with an optional output register stage,
// occupancy count, registered almost-full/almost-empty flags and synchronous flush.
module stream_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int REG_OUT    = 0,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  stream_fifo_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]         AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0]         AE_CNT   = CW'(AE_LEVEL);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d, st_cnt_q, st_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  af_q, af_d, ae_q, ae_d;
  logic                  run_q;
  logic                  s_ready_s, push_s, pop_s, load_s;

  // Handshakes, prefetch decision and next-state for pointers, counts, output stage and flags.
  always_comb begin
    s_ready_s   = run_q & (count_q != FULL_CNT) & ~flush;
    push_s      = bus.s_valid & s_ready_s;
    pop_s       = out_valid_q & bus.m_ready & ~flush;
    load_s      = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    st_cnt_d    = st_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (flush) begin
      rd_ptr_d    = wr_ptr_q;
      count_d     = {CW{1'b0}};
      st_cnt_d    = {CW{1'b0}};
      out_valid_d = 1'b0;
    end else begin
      // With an output flop, storage only drains into the flop; otherwise a pop reads storage directly.
      if (REG_OUT != 0) begin
        load_s = (st_cnt_q != {CW{1'b0}}) & (~out_valid_q | pop_s);
      end else begin
        load_s = pop_s;
      end
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (load_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d  = count_q + CW'(push_s) - CW'(pop_s);
      st_cnt_d = st_cnt_q + CW'(push_s) - CW'(load_s);
      if (REG_OUT != 0) begin
        if (load_s) begin
          out_data_d  = mem_q[rd_ptr_q];
          out_valid_d = 1'b1;
        end else if (pop_s) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end else begin
        out_valid_d = (count_d != {CW{1'b0}});
      end
    end
    af_d = (count_d >= AF_CNT);
    ae_d = (count_d <= AE_CNT);
  end

  // Storage array: written on push only, never reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= bus.s_data;
    end
  end

  // Control state, output stage and flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= {ADDR_WIDTH{1'b0}};
      rd_ptr_q    <= {ADDR_WIDTH{1'b0}};
      count_q     <= {CW{1'b0}};
      st_cnt_q    <= {CW{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {DATA_WIDTH{1'b0}};
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      run_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      st_cnt_q    <= st_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      run_q       <= 1'b1;
    end
  end

  assign bus.s_ready      = s_ready_s;
  assign bus.m_valid      = out_valid_q;
  assign bus.m_data       = (REG_OUT != 0) ? out_data_q : mem_q[rd_ptr_q];
  assign bus.count        = count_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
endmodule

// File: tb/tb_stream_fifo.sv
// Drives a direct-read FIFO and a registered-output FIFO with identical stimulus and checks
// both against per-instance queue models of occupancy, visibility and word order.
module tb_stream_fifo;
  localparam int DW = 8, AW = 2, DEPTH = 4, AF = 3, AE = 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = 8'h00;
  logic          m_ready = 1'b0;
  int            n_vec = 0;
  int            n_err = 0;

  stream_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();
  stream_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();
  assign if0.s_valid = s_valid;
  assign if0.s_data  = s_data;
  assign if0.m_ready = m_ready;
  assign if1.s_valid = s_valid;
  assign if1.s_data  = s_data;
  assign if1.m_ready = m_ready;

  stream_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_OUT(0), .AF_LEVEL(AF), .AE_LEVEL(AE))
    u_dut0 (.clk(clk), .reset_n(reset_n), .flush(flush), .bus(if0.slave));
  stream_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_OUT(1), .AF_LEVEL(AF), .AE_LEVEL(AE))
    u_dut1 (.clk(clk), .reset_n(reset_n), .flush(flush), .bus(if1.slave));

  always #5 clk = ~clk;

  // Reference model: contents in order; pl = a word entered at the last edge.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  bit pl0 = 1'b0, pl1 = 1'b0, run_m = 1'b0;

  function automatic bit exp_ready(int sz);
    return run_m && (sz != DEPTH) && !flush;
  endfunction
  function automatic bit exp_mv0();
    return q0.size() != 0;
  endfunction
  function automatic bit exp_mv1();
    return (q1.size() - int'(pl1)) != 0;
  endfunction

  task automatic model_step();
    bit pu0, pu1, po0, po1, fl;
    logic [DW-1:0] d;
    pu0 = s_valid && exp_ready(q0.size());
    pu1 = s_valid && exp_ready(q1.size());
    po0 = m_ready && exp_mv0() && !flush;
    po1 = m_ready && exp_mv1() && !flush;
    fl  = flush;
    d   = s_data;
    @(posedge clk);
    #1;
    if (fl) begin
      q0.delete(); q1.delete(); pl0 = 1'b0; pl1 = 1'b0;
    end else begin
      if (po0) void'(q0.pop_front());
      if (po1) void'(q1.pop_front());
      if (pu0) q0.push_back(d);
      if (pu1) q1.push_back(d);
      pl0 = pu0; pl1 = pu1;
    end
    run_m = 1'b1;
  endtask

  task automatic drain();
    s_valid = 1'b0; m_ready = 1'b1; flush = 1'b0;
    for (int i = 0; i < 16 && (q0.size() != 0 || q1.size() != 0); i++) model_step();
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec += 6;
    if (if0.count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", if0.count); end
    if (if0.m_valid !== 1'b0 || if1.m_valid !== 1'b0) begin n_err++; $display("FAIL reset_mvalid got %b/%b exp 0/0", if0.m_valid, if1.m_valid); end
    if (if0.s_ready !== 1'b0 || if1.s_ready !== 1'b0) begin n_err++; $display("FAIL reset_sready got %b/%b exp 0/0", if0.s_ready, if1.s_ready); end
    if (if0.almost_full !== 1'b0) begin n_err++; $display("FAIL reset_af got %b exp 0", if0.almost_full); end
    if (if0.almost_empty !== 1'b1 || if1.almost_empty !== 1'b1) begin n_err++; $display("FAIL reset_ae got %b/%b exp 1/1", if0.almost_empty, if1.almost_empty); end
    if (if1.m_data !== 8'h00) begin n_err++; $display("FAIL reset_mdata_reg got %h exp 00", if1.m_data); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_vec++;
    if (if0.s_ready !== 1'b0) begin n_err++; $display("FAIL release_sready_early got %b exp 0", if0.s_ready); end
    model_step();
    n_vec++;
    if (if0.s_ready !== 1'b1 || if1.s_ready !== 1'b1) begin n_err++; $display("FAIL release_sready got %b/%b exp 1/1", if0.s_ready, if1.s_ready); end
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] pat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = pat[i];
      model_step();
    end
    s_data = 8'h99;
    n_vec += 4;
    if (if0.s_ready !== 1'b0 || if1.s_ready !== 1'b0) begin n_err++; $display("FAIL full_sready got %b/%b exp 0/0", if0.s_ready, if1.s_ready); end
    if (if0.count !== 3'd4 || if1.count !== 3'd4) begin n_err++; $display("FAIL full_count got %0d/%0d exp 4", if0.count, if1.count); end
    if (if0.almost_full !== 1'b1) begin n_err++; $display("FAIL full_af got %b exp 1", if0.almost_full); end
    if (if0.almost_empty !== 1'b0) begin n_err++; $display("FAIL full_ae got %b exp 0", if0.almost_empty); end
    model_step();
    n_vec++;
    if (if0.count !== 3'd4) begin n_err++; $display("FAIL full_push_ignored count got %0d exp 4", if0.count); end
    s_valid = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec += 2;
      if (if0.m_valid !== 1'b1 || if0.m_data !== pat[i]) begin n_err++; $display("FAIL drain_%0d got v=%b d=%h exp v=1 d=%h", i, if0.m_valid, if0.m_data, pat[i]); end
      if (if1.m_valid !== 1'b1 || if1.m_data !== pat[i]) begin n_err++; $display("FAIL drain_reg_%0d got v=%b d=%h exp v=1 d=%h", i, if1.m_valid, if1.m_data, pat[i]); end
      model_step();
    end
    m_ready = 1'b0;
    n_vec += 2;
    if (if0.m_valid !== 1'b0 || if1.m_valid !== 1'b0) begin n_err++; $display("FAIL empty_mvalid got %b/%b exp 0/0", if0.m_valid, if1.m_valid); end
    if (if0.count !== 3'd0 || if1.count !== 3'd0) begin n_err++; $display("FAIL empty_count got %0d/%0d exp 0", if0.count, if1.count); end
  endtask

  task automatic test_latency();
    s_valid = 1'b1; s_data = 8'hA5;
    model_step();
    s_valid = 1'b0;
    n_vec += 3;
    if (if0.m_valid !== 1'b1 || if0.m_data !== 8'hA5) begin n_err++; $display("FAIL lat_direct got v=%b d=%h exp v=1 d=a5", if0.m_valid, if0.m_data); end
    if (if1.m_valid !== 1'b0) begin n_err++; $display("FAIL lat_reg_early got v=%b exp 0", if1.m_valid); end
    if (if1.count !== 3'd1) begin n_err++; $display("FAIL lat_reg_count got %0d exp 1", if1.count); end
    model_step();
    n_vec++;
    if (if1.m_valid !== 1'b1 || if1.m_data !== 8'hA5) begin n_err++; $display("FAIL lat_reg got v=%b d=%h exp v=1 d=a5", if1.m_valid, if1.m_data); end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] nxt = 8'h00;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_data = DW'(i);
      model_step();
    end
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_data = DW'(i + 2);
      n_vec += 3;
      if (if0.count !== 3'd2 || if1.count !== 3'd2) begin n_err++; $display("FAIL b2b_count_%0d got %0d/%0d exp 2", i, if0.count, if1.count); end
      if (if0.m_valid !== 1'b1 || if0.m_data !== nxt) begin n_err++; $display("FAIL b2b_direct_%0d got v=%b d=%h exp v=1 d=%h", i, if0.m_valid, if0.m_data, nxt); end
      if (if1.m_valid !== 1'b1 || if1.m_data !== nxt) begin n_err++; $display("FAIL b2b_reg_%0d got v=%b d=%h exp v=1 d=%h", i, if1.m_valid, if1.m_data, nxt); end
      model_step();
      nxt = nxt + 8'd1;
    end
    drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = DW'(8'h30 + i);
      model_step();
    end
    flush = 1'b1; s_valid = 1'b1; s_data = 8'hEE; m_ready = 1'b1;
    #1;
    n_vec++;
    if (if0.s_ready !== 1'b0 || if1.s_ready !== 1'b0) begin n_err++; $display("FAIL flush_sready got %b/%b exp 0/0", if0.s_ready, if1.s_ready); end
    model_step();
    flush = 1'b0; s_valid = 1'b0;
    n_vec += 3;
    if (if0.count !== 3'd0 || if1.count !== 3'd0) begin n_err++; $display("FAIL flush_count got %0d/%0d exp 0", if0.count, if1.count); end
    if (if0.m_valid !== 1'b0 || if1.m_valid !== 1'b0) begin n_err++; $display("FAIL flush_mvalid got %b/%b exp 0/0", if0.m_valid, if1.m_valid); end
    if (if0.almost_empty !== 1'b1 || if0.almost_full !== 1'b0) begin n_err++; $display("FAIL flush_flags got ae=%b af=%b exp ae=1 af=0", if0.almost_empty, if0.almost_full); end
    for (int i = 0; i < 2; i++) begin
      model_step();
      n_vec++;
      if (if0.m_valid !== 1'b0 || if1.m_valid !== 1'b0) begin n_err++; $display("FAIL flush_dropped_%0d got %b/%b exp 0/0", i, if0.m_valid, if1.m_valid); end
    end
    m_ready = 1'b0;
  endtask

  task automatic test_stall();
    s_valid = 1'b1; s_data = 8'h5C; model_step();
    s_data = 8'h77; model_step();
    s_valid = 1'b0; m_ready = 1'b0; model_step();
    for (int i = 0; i < 10; i++) begin
      n_vec += 2;
      if (if0.m_valid !== 1'b1 || if0.m_data !== 8'h5C || if1.m_valid !== 1'b1 || if1.m_data !== 8'h5C)
        begin n_err++; $display("FAIL stall_data_%0d got %b:%h/%b:%h exp 1:5c", i, if0.m_valid, if0.m_data, if1.m_valid, if1.m_data); end
      if (if0.count !== 3'd2 || if1.count !== 3'd2) begin n_err++; $display("FAIL stall_count_%0d got %0d/%0d exp 2", i, if0.count, if1.count); end
      model_step();
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      s_valid = ($urandom_range(3) != 0);
      m_ready = ($urandom_range(2) != 0);
      s_data  = DW'($urandom_range(255));
      flush   = ($urandom_range(63) == 0);
      #1;
      n_vec += 8;
      if (if0.count !== 3'(q0.size()) || if1.count !== 3'(q1.size())) begin n_err++; $display("FAIL rnd_count @%0d got %0d/%0d exp %0d/%0d", i, if0.count, if1.count, q0.size(), q1.size()); end
      if (if0.s_ready !== exp_ready(q0.size()) || if1.s_ready !== exp_ready(q1.size())) begin n_err++; $display("FAIL rnd_sready @%0d got %b/%b", i, if0.s_ready, if1.s_ready); end
      if (if0.m_valid !== exp_mv0()) begin n_err++; $display("FAIL rnd_mvalid0 @%0d got %b exp %b", i, if0.m_valid, exp_mv0()); end
      if (if1.m_valid !== exp_mv1()) begin n_err++; $display("FAIL rnd_mvalid1 @%0d got %b exp %b", i, if1.m_valid, exp_mv1()); end
      if (exp_mv0() && if0.m_data !== q0[0]) begin n_err++; $display("FAIL rnd_data0 @%0d got %h exp %h", i, if0.m_data, q0[0]); end
      if (exp_mv1() && if1.m_data !== q1[0]) begin n_err++; $display("FAIL rnd_data1 @%0d got %h exp %h", i, if1.m_data, q1[0]); end
      if (if0.almost_full !== (q0.size() >= AF) || if1.almost_full !== (q1.size() >= AF)) begin n_err++; $display("FAIL rnd_af @%0d got %b/%b", i, if0.almost_full, if1.almost_full); end
      if (if0.almost_empty !== (q0.size() <= AE) || if1.almost_empty !== (q1.size() <= AE)) begin n_err++; $display("FAIL rnd_ae @%0d got %b/%b", i, if0.almost_empty, if1.almost_empty); end
      model_step();
    end
    flush = 1'b0;
    drain();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = DW'(8'hC0 + i);
      model_step();
    end
    #2;
    reset_n = 1'b0;
    q0.delete(); q1.delete(); pl0 = 1'b0; pl1 = 1'b0; run_m = 1'b0;
    #1;
    n_vec += 3;
    if (if0.count !== 3'd0 || if1.count !== 3'd0) begin n_err++; $display("FAIL areset_count got %0d/%0d exp 0", if0.count, if1.count); end
    if (if0.m_valid !== 1'b0 || if1.m_valid !== 1'b0) begin n_err++; $display("FAIL areset_mvalid got %b/%b exp 0/0", if0.m_valid, if1.m_valid); end
    if (if0.s_ready !== 1'b0) begin n_err++; $display("FAIL areset_sready got %b exp 0", if0.s_ready); end
    s_valid = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    model_step();
    n_vec += 2;
    if (if0.s_ready !== 1'b1 || if1.s_ready !== 1'b1) begin n_err++; $display("FAIL areset_release_sready got %b/%b exp 1/1", if0.s_ready, if1.s_ready); end
    if (if0.count !== 3'd0) begin n_err++; $display("FAIL areset_release_count got %0d exp 0", if0.count); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_latency();
    test_back_to_back();
    test_flush();
    test_stall();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
